// File: rtl/regfile_wb_scheduler_pkg.sv
// Shared types for the writeback scheduler: FSM state, pending-destination
// record and the architectural link register index.
package wb_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        WB   = 2'd2
    } sched_state_t;

    typedef struct packed {
        logic       valid;
        logic       fp;
        logic [4:0] rd;
    } pend_rec_t;

    localparam logic [4:0] GPR_LINK_REG = 5'd31;

endpackage

// File: rtl/regfile_wb_scheduler_if.sv
// ID-stage <-> writeback scheduler bundle. The ID side is the master and the
// scheduler is the slave. Optional stall statistics (STALL_STATS_EN) add
// three counters on the slave side.
interface regfile_wb_scheduler_if;
    logic       issue_valid;
    logic       issue_long;
    logic       issue_wr;
    logic       issue_fp_dst;
    logic [4:0] issue_rd;
    logic [4:0] issue_rs;
    logic       issue_rs_fp;
    logic [4:0] issue_rt;
    logic       issue_rt_fp;
    logic       issue_rt_used;
    logic [3:0] issue_lat;

    logic       stall;
    logic       busy;
    logic       long_start;
    logic       long_wb;
    logic       long_wb_fp;
    logic [4:0] long_wb_rd;
`ifdef STALL_STATS_EN
    logic [31:0] stat_hazard_cnt;
    logic [31:0] stat_struct_cnt;
    logic [31:0] stat_port_cnt;
`endif

    modport master (
        output issue_valid, issue_long, issue_wr, issue_fp_dst, issue_rd,
               issue_rs, issue_rs_fp, issue_rt, issue_rt_fp, issue_rt_used,
               issue_lat,
        input  stall, busy, long_start, long_wb, long_wb_fp, long_wb_rd
`ifdef STALL_STATS_EN
        , input stat_hazard_cnt, stat_struct_cnt, stat_port_cnt
`endif
    );

    modport slave (
        input  issue_valid, issue_long, issue_wr, issue_fp_dst, issue_rd,
               issue_rs, issue_rs_fp, issue_rt, issue_rt_fp, issue_rt_used,
               issue_lat,
        output stall, busy, long_start, long_wb, long_wb_fp, long_wb_rd
`ifdef STALL_STATS_EN
        , output stat_hazard_cnt, stat_struct_cnt, stat_port_cnt
`endif
    );
endinterface

// File: rtl/regfile_wb_scheduler_lat_counter.sv
// Long-op latency down-counter: load, decrement, terminal-count (cnt==1).
module wb_lat_counter #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_load,
    input  logic [CW-1:0] i_load_val,
    input  logic          i_dec,
    output logic          o_tc
);
    logic [CW-1:0] r_cnt;

    // Load has priority; decrement never wraps below zero.
    always_ff @(posedge clk) begin
        if (reset)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= i_load_val;
        else if (i_dec && (r_cnt != '0))
            r_cnt <= r_cnt - CW'(1);
    end

    assign o_tc = (r_cnt == CW'(1));
endmodule

// File: rtl/regfile_wb_scheduler.sv
// Issue/writeback scheduler: tracks one in-flight long-latency op, stalls ID
// on hazards against its destination and on write-port conflicts in its
// writeback cycle, and drives the long unit start / writeback strobes.
// Optional feature macro: STALL_STATS_EN (stall-cause counters).
module regfile_wb_scheduler
    import wb_sched_pkg::*;
#(
    parameter int MAX_LAT            = 15,
    parameter bit GPR_ZERO_HARDWIRED = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    regfile_wb_scheduler_if.slave   bus
);
    localparam int CW = $clog2(MAX_LAT + 1);

    sched_state_t  r_state;
    sched_state_t  w_state_nxt;
    pend_rec_t     r_pend;
    logic          r_last_fp;
    logic [4:0]    r_last_rd;
    logic [CW-1:0] w_lat;
    logic          w_in_busy, w_in_wb;
    logic          w_hazard, w_s1, w_s2, w_s3;
    logic          w_accept, w_start, w_cnt_tc, w_lat_one, w_dst_r0;

    assign w_in_busy = (r_state == BUSY);
    assign w_in_wb   = (r_state == WB);

    // Effective latency: 0 behaves as 1, oversize values clamp to MAX_LAT.
    always_comb begin
        if (bus.issue_lat == 4'd0)
            w_lat = CW'(1);
        else if (int'(bus.issue_lat) > MAX_LAT)
            w_lat = CW'(MAX_LAT);
        else
            w_lat = CW'(bus.issue_lat);
    end
    assign w_lat_one = (w_lat == CW'(1));

    // Register-level RAW/WAW match against the pending destination.
    always_comb begin
        w_hazard = 1'b0;
        if (r_pend.valid) begin
            if ((bus.issue_rs == r_pend.rd) && (bus.issue_rs_fp == r_pend.fp))
                w_hazard = 1'b1;
            if (bus.issue_rt_used && (bus.issue_rt == r_pend.rd) &&
                (bus.issue_rt_fp == r_pend.fp))
                w_hazard = 1'b1;
            if (bus.issue_wr && (bus.issue_rd == r_pend.rd) &&
                (bus.issue_fp_dst == r_pend.fp))
                w_hazard = 1'b1;
        end
    end

    // S1 data hazard, S2 unit busy, S3 write port taken by the long result.
    assign w_s1 = (w_in_busy | w_in_wb) & w_hazard;
    assign w_s2 = bus.issue_long & w_in_busy;
    assign w_s3 = w_in_wb & bus.issue_wr & ~bus.issue_long &
                  (bus.issue_fp_dst == r_pend.fp);

    assign bus.stall      = bus.issue_valid & (w_s1 | w_s2 | w_s3);
    assign w_accept       = bus.issue_valid & ~bus.stall;
    assign w_start        = w_accept & bus.issue_long;
    assign bus.long_start = w_start;

    // Latency 1 goes straight to WB; longer ops count down L-1 BUSY cycles.
    wb_lat_counter #(.CW(CW)) u_cnt (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_start & ~w_lat_one),
        .i_load_val (w_lat - CW'(1)),
        .i_dec      (w_in_busy),
        .o_tc       (w_cnt_tc)
    );

    // Next-state: IDLE and WB both launch a new op; WB otherwise retires.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE, WB: begin
                if (w_start)
                    w_state_nxt = w_lat_one ? WB : BUSY;
                else
                    w_state_nxt = IDLE;
            end
            BUSY:     if (w_cnt_tc) w_state_nxt = WB;
            default:  w_state_nxt = IDLE;
        endcase
    end

    // State register; reset abandons any in-flight op.
    always_ff @(posedge clk) begin
        if (reset)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Pending record: reloaded on every long launch, invalidated on retire.
    // A write to hardwired r0 never needs tracking or writeback.
    assign w_dst_r0 = GPR_ZERO_HARDWIRED & ~bus.issue_fp_dst & (bus.issue_rd == 5'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend <= '0;
        end else if (w_start) begin
            r_pend.valid <= bus.issue_wr & ~w_dst_r0;
            if (bus.issue_wr) begin
                r_pend.fp <= bus.issue_fp_dst;
                r_pend.rd <= bus.issue_rd;
            end
        end else if (w_in_wb) begin
            r_pend.valid <= 1'b0;
        end
    end

    // Remember the last writeback target so the port outputs hold outside WB.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_fp <= 1'b0;
            r_last_rd <= 5'd0;
        end else if (w_in_wb) begin
            r_last_fp <= r_pend.fp;
            r_last_rd <= r_pend.rd;
        end
    end

    assign bus.busy       = (r_state != IDLE);
    assign bus.long_wb    = w_in_wb & r_pend.valid;
    assign bus.long_wb_fp = w_in_wb ? r_pend.fp : r_last_fp;
    assign bus.long_wb_rd = w_in_wb ? r_pend.rd : r_last_rd;

`ifdef STALL_STATS_EN
    logic [31:0] r_stat_hazard, r_stat_struct, r_stat_port;

    // One count per stall cycle, attributed S1 > S2 > S3, saturating.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stat_hazard <= '0;
            r_stat_struct <= '0;
            r_stat_port   <= '0;
        end else if (bus.stall) begin
            if (w_s1) begin
                if (r_stat_hazard != '1) r_stat_hazard <= r_stat_hazard + 32'd1;
            end else if (w_s2) begin
                if (r_stat_struct != '1) r_stat_struct <= r_stat_struct + 32'd1;
            end else begin
                if (r_stat_port != '1)   r_stat_port   <= r_stat_port + 32'd1;
            end
        end
    end

    assign bus.stat_hazard_cnt = r_stat_hazard;
    assign bus.stat_struct_cnt = r_stat_struct;
    assign bus.stat_port_cnt   = r_stat_port;
`endif
endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Bench for regfile_wb_scheduler: directed scenarios followed by random
// traffic, checked each cycle against a time-stamped model of the in-flight op.
module tb_regfile_wb_scheduler;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    regfile_wb_scheduler_if bus();

    regfile_wb_scheduler #(.MAX_LAT(15), .GPR_ZERO_HARDWIRED(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Model: one in-flight op described by its absolute writeback cycle.
    bit         m_inflight;
    int         m_wb_at;
    bit         m_pv, m_pfp, m_lfp;
    logic [4:0] m_prd, m_lrd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic drv(input bit v, input bit lng, input bit wr, input bit fpd,
                       input int rd, input int rs, input bit rsfp,
                       input int rt, input bit rtfp, input bit rtu, input int lat);
        bus.issue_valid   = v;
        bus.issue_long    = lng;
        bus.issue_wr      = wr;
        bus.issue_fp_dst  = fpd;
        bus.issue_rd      = 5'(rd);
        bus.issue_rs      = 5'(rs);
        bus.issue_rs_fp   = rsfp;
        bus.issue_rt      = 5'(rt);
        bus.issue_rt_fp   = rtfp;
        bus.issue_rt_used = rtu;
        bus.issue_lat     = 4'(lat);
    endtask

    task automatic model_clear();
        m_inflight = 0; m_wb_at = 0;
        m_pv = 0; m_pfp = 0; m_prd = 5'd0;
        m_lfp = 0; m_lrd = 5'd0;
    endtask

    // One clock: check outputs mid-cycle, advance the model, then clock.
    task automatic cycle();
        bit in_wb, in_busy, pv, haz, e_stall, acc;
        int L;
        @(negedge clk);
        if (reset) begin
            model_clear();
        end else begin
            in_wb   = m_inflight && (cyc == m_wb_at);
            in_busy = m_inflight && (cyc <  m_wb_at);
            pv      = (in_wb || in_busy) && m_pv;
            haz = pv && (((bus.issue_rs == m_prd) && (bus.issue_rs_fp == m_pfp)) ||
                         (bus.issue_rt_used && (bus.issue_rt == m_prd) && (bus.issue_rt_fp == m_pfp)) ||
                         (bus.issue_wr && (bus.issue_rd == m_prd) && (bus.issue_fp_dst == m_pfp)));
            e_stall = bus.issue_valid && (haz || (bus.issue_long && in_busy) ||
                      (in_wb && bus.issue_wr && !bus.issue_long && (bus.issue_fp_dst == m_pfp)));
            acc = bus.issue_valid && !e_stall;
            chk("stall",      32'(bus.stall),      32'(e_stall));
            chk("busy",       32'(bus.busy),       32'(m_inflight));
            chk("long_start", 32'(bus.long_start), 32'(acc && bus.issue_long));
            chk("long_wb",    32'(bus.long_wb),    32'(in_wb && m_pv));
            chk("long_wb_fp", 32'(bus.long_wb_fp), 32'(in_wb ? m_pfp : m_lfp));
            chk("long_wb_rd", 32'(bus.long_wb_rd), 32'(in_wb ? m_prd : m_lrd));
            if (in_wb) begin
                m_lfp = m_pfp; m_lrd = m_prd;
            end
            if (acc && bus.issue_long) begin
                L = (bus.issue_lat == 0) ? 1 : ((int'(bus.issue_lat) > 15) ? 15 : int'(bus.issue_lat));
                m_inflight = 1;
                m_wb_at    = cyc + L;
                if (bus.issue_wr) begin
                    m_pfp = bus.issue_fp_dst;
                    m_prd = bus.issue_rd;
                    m_pv  = !(!bus.issue_fp_dst && bus.issue_rd == 5'd0);
                end else begin
                    m_pv = 0;
                end
            end else if (in_wb) begin
                m_inflight = 0;
                m_pv = 0;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic long_op(input bit fpd, input int rd, input int lat);
        drv(1, 1, 1, fpd, rd, 1, 1, 2, 1, 0, lat);
        cycle();
    endtask

    initial begin
        model_clear();
        reset = 1'b1;
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_busy",    32'(bus.busy),       32'd0);
        chk("rst_long_wb", 32'(bus.long_wb),    32'd0);
        chk("rst_wb_fp",   32'(bus.long_wb_fp), 32'd0);
        chk("rst_wb_rd",   32'(bus.long_wb_rd), 32'd0);
        chk("rst_stall",   32'(bus.stall),      32'd0);
        chk("rst_start",   32'(bus.long_start), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(2);

        // GPR r5, lat 4, then read r5 until it clears (4 stalls, then accept).
        long_op(0, 5, 4);
        drv(1, 0, 0, 0, 0, 5, 0, 0, 0, 0, 0);
        repeat (5) cycle();
        idle(1);

        // Read FPR f5 while busy (no stall), then GPR r9 write at WB (port conflict).
        long_op(0, 5, 4);
        drv(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0);
        repeat (3) cycle();
        drv(1, 0, 1, 0, 9, 1, 1, 1, 1, 0, 0);
        repeat (2) cycle();
        idle(1);

        // FPR f9 write at a GPR writeback cycle: no conflict.
        long_op(0, 5, 4);
        idle(3);
        drv(1, 0, 1, 1, 9, 1, 1, 1, 1, 0, 0);
        cycle();
        idle(1);

        // Second long op stalls in BUSY, launches back-to-back from WB with lat 1.
        long_op(0, 6, 3);
        drv(1, 1, 1, 0, 7, 1, 1, 2, 1, 0, 1);
        repeat (3) cycle();
        idle(3);

        // r0 destination: reads of r0 are free, another long op still waits.
        long_op(0, 0, 5);
        drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        repeat (2) cycle();
        drv(1, 1, 1, 1, 3, 1, 1, 2, 1, 0, 2);
        repeat (2) cycle();
        idle(6);

        // Reset while BUSY with two cycles left: op is dropped.
        long_op(0, 5, 6);
        idle(4);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        drv(1, 0, 0, 0, 0, 5, 0, 0, 0, 0, 0);
        cycle();
        idle(8);

        // Long op without a destination, and latency 0 behaving as 1.
        drv(1, 1, 0, 0, 4, 1, 1, 2, 1, 0, 2);
        cycle();
        idle(3);
        long_op(1, 12, 0);
        drv(1, 0, 0, 0, 0, 12, 1, 0, 0, 0, 0);
        repeat (2) cycle();
        idle(2);

        // Random traffic with a small register window to provoke collisions.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                reset = 1'b1;
                drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
                cycle();
                reset = 1'b0;
            end else begin
                drv($urandom_range(0, 9) < 7, $urandom_range(0, 4) == 0,
                    $urandom_range(0, 3) != 0, 1'($urandom),
                    $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom),
                    $urandom_range(0, 3), 1'($urandom), 1'($urandom),
                    $urandom_range(0, 15));
                cycle();
            end
        end
        idle(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/regfile_wb_scheduler.md
Name: regfile_wb_scheduler

Overview:
Issue/writeback scheduler sitting beside the ID stage. It lets the single-cycle datapath share the GPR and FPR write ports with one long-latency execution unit (integer mul/div, FP multiply).
- Tracks the single in-flight long operation.
- Stalls ID on RAW/WAW hazards against its pending destination.
- Stalls ID on write-port conflicts in the long op's writeback cycle.
- Produces the long unit's start pulse and write-back enables.

Parameters:
MAX_LAT, 15, largest supported long-op latency in cycles (counter width = $clog2(MAX_LAT+1))
GPR_ZERO_HARDWIRED, 1, 1 = GPR r0 never tracked as a hazard

Ports:
clk  in  1  clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
issue_valid  in  1  ID holds a valid instruction this cycle
issue_long  in  1  instruction goes to the long-latency unit
issue_wr  in  1  instruction writes a register (GPR or FPR)
issue_fp_dst  in  1  destination is FPR (0 = GPR)
issue_rd  in  5  destination index, already resolved for REG_DST / JAL r31
issue_rs  in  5  source A index
issue_rs_fp  in  1  source A read from FPR
issue_rt  in  5  source B index
issue_rt_fp  in  1  source B read from FPR
issue_rt_used  in  1  source B actually read (0 for immediate forms)
issue_lat  in  4  latency of this long op; 0 is treated as 1; values above MAX_LAT saturate to MAX_LAT
stall  out  1  hold PC/ID this cycle; instruction is not accepted
busy  out  1  long op in flight (state != IDLE)
long_start  out  1  one-cycle launch pulse to the long unit
long_wb  out  1  write enable for the long result this cycle
long_wb_fp  out  1  long result targets FPR
long_wb_rd  out  5  long result destination index

Behaviour:
- Reset values: all outputs 0; state IDLE; counter 0; pending registers 0.
- Reset mid-operation: the in-flight op is abandoned and no long_wb pulse is issued.
- accept = issue_valid & ~stall. long_start = accept & issue_long (combinational, same cycle).
- Pending record:
  - Holds {pend_valid, pend_fp, pend_rd}.
  - Loaded on accept & issue_long & issue_wr.
  - If GPR_ZERO_HARDWIRED and the destination is GPR r0, pend_valid = 0.
- hazard (when pend_valid) = any of:
  - (issue_rs, issue_rs_fp) == (pend_rd, pend_fp)
  - issue_rt_used & (issue_rt, issue_rt_fp) == (pend_rd, pend_fp)
  - issue_wr & (issue_rd, issue_fp_dst) == (pend_rd, pend_fp)
- stall = issue_valid & (S1 | S2 | S3):
  - S1: hazard in BUSY or WB. The result is written at the end of WB and is readable the next cycle.
  - S2: issue_long while in BUSY (only one long op in flight).
  - S3: state WB & issue_wr & ~issue_long & (issue_fp_dst == pend_fp). This is a port conflict; single-cycle writes commit in their ID cycle.
- FSM (IDLE, BUSY, WB). For a long op accepted at cycle t, long_wb = 1 exactly at cycle t+L, where L is the effective latency.
  - IDLE: on accepted long op, L==1 → WB, else BUSY with cnt <= L-1.
  - BUSY: cnt decrements each cycle; when cnt==1 → WB.
  - WB: long_wb = 1, and long_wb_fp/long_wb_rd = the pending record.
    - A long op accepted in the same cycle → BUSY or WB (back-to-back) and reloads the pending record.
    - Otherwise → IDLE and pend_valid cleared.
- Long op with issue_wr = 0: the FSM still runs and occupies the unit, but long_wb stays 0 in WB.
- long_wb_fp and long_wb_rd hold their last value outside WB.

Optional Feature:
STALL_STATS_EN
- Defined: adds outputs stat_hazard_cnt[32], stat_struct_cnt[32] and stat_port_cnt[32].
  - These count stall cycles caused by S1, S2 and S3 respectively. S1 takes precedence, then S2, so each stall cycle is counted once.
  - Counters saturate at all-ones and clear on reset.
- Undefined: the ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package wb_sched_pkg holds:
  - typedef sched_state_t {IDLE, BUSY, WB}.
  - typedef pend_rec_t {valid, fp, rd[5]}.
  - constant GPR_LINK_REG = 31.
- One sub-module: wb_lat_counter (load / decrement / terminal-count flag).

Test Plan:
- Long GPR op rd=5, lat=4, accepted at t=10 → long_start at 10; busy 11..14; long_wb=1, rd=5, fp=0 at cycle 14 only.
- In BUSY, an instruction reads GPR r5 → stall=1 through cycle 14; accepted at 15. Reading FPR f5 instead → no stall.
- At the WB cycle, a single-cycle op writes GPR r9 → stall for one cycle. The same op writing FPR f9 → no stall.
- Second long op during BUSY → stalled. Issued in the WB cycle with lat=1 → accepted, long_wb again at the next cycle with the new rd.
- Long op with destination GPR r0, then a read of r0 during BUSY → no hazard stall. A second long op is still stalled (S2).
- Assert reset in BUSY with cnt=2 → next cycle busy=0, no long_wb ever, a pending-register read is not stalled.
